uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter (serial_out path) between NUM_REQ byte
//  sources, e.g. CPU MMIO TX and the button/status reporter. Fair round-robin
//  across sources, one byte per grant. Sits between requesters and uart_transmitter.
//  One registered byte buffer on the output; ready/valid on both sides.
// PARAMETERS
//  NUM_REQ  2  number of requesters, 2..8
//  IDW      $clog2(NUM_REQ) (derived localparam)  width of grant_id
// PORTS
//  clk          in   1           system clock (cpu_clk domain)
//  rst          in   1           asynchronous, active-high reset
//  req_valid    in   NUM_REQ     per-requester byte valid
//  req_data     in   8*NUM_REQ   per-requester byte, req i at [8*i+7:8*i]
//  req_lock     in   NUM_REQ     per-requester keep-grant flag (LOCK_EN only)
//  req_ready    out  NUM_REQ     per-requester byte accepted this cycle
//  out_valid    out  1           byte to transmitter valid
//  out_data     out  8           byte to transmitter
//  out_ready    in   1           transmitter accepts (data_in_ready)
//  grant_id     out  IDW         index of source owning out_data
//  busy         out  1           out buffer occupied or lock held
// BEHAVIOUR
//  Reset (async): state=IDLE, out_valid=0, out_data=0, grant_id=0, rr_ptr=0,
//   busy=0, lock_held=0; req_ready=0 (combinational, gated by state).
//  States: IDLE, BUSY.
//  IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ...
//   mod NUM_REQ. req_ready[winner]=1 in the same cycle (combinational, one-hot,
//   only in IDLE). At the clock edge: out_data<=byte, out_valid<=1,
//   grant_id<=winner, ->BUSY. No valid -> stay IDLE, all ready=0.
//  BUSY: out_valid=1, out_data held stable; all req_ready=0.
//   out_valid&&out_ready -> out_valid<=0, rr_ptr<=(grant_id+1) mod NUM_REQ, ->IDLE.
//  Latency: req accepted in cycle t -> out_valid at t+1; max one byte per
//   2 cycles (ample for UART).
//  rr_ptr wraps NUM_REQ-1 -> 0. Single requester continuously valid: served
//   back to back every 2 cycles. All NUM_REQ valid: served in order rr_ptr..,
//   each exactly once per NUM_REQ grants (no starvation).
//  req_valid dropped before acceptance: no effect, nothing captured.
//  out_ready high while IDLE: ignored.
//  Reset mid-BUSY: buffered byte discarded, out_valid drops asynchronously.
//  busy = (state==BUSY) | lock_held.
// CONFIGURATION
//  UART_ARB_LOCK_EN defined: req_lock[winner] is sampled with each accepted
//   byte; if 1, lock_held<=1 and owner<=winner. In IDLE with lock_held, only
//   owner can win: other req_ready stay 0 even if owner is idle. rr_ptr is not
//   advanced. Owner byte accepted with req_lock=0 -> lock_held<=0, normal
//   round-robin resumes from owner+1. Use: multi-byte message not interleaved.
//  Not defined: req_lock ignored, lock_held tied 0, pure per-byte round-robin.
//  The port list is the same in both builds.
// TESTING
//  1 Reset: rst pulse mid-BUSY -> out_valid=0 immediately, rr_ptr=0, grant_id=0.
//  2 req0 only, data 0x41, out_ready=1 -> req_ready[0] cycle t, out_valid t+1
//    with 0x41, grant_id=0, IDLE at t+2.
//  3 NUM_REQ=2, both valid for 6 grants (0x10.. / 0x20..), out_ready=1 ->
//    output order 0x10,0x20,0x11,0x21,0x12,0x22.
//  4 Backpressure: out_ready=0 for 100 cycles with byte 0x55 -> out_data
//    stable, req_ready all 0; out_ready=1 -> one transfer, back to IDLE.
//  5 LOCK_EN: req0 sends 3 bytes lock=1,1,0 while req1 valid -> req0's 3
//    bytes contiguous, then req1; without macro they interleave 0,1,0,1,0.
//  6 NUM_REQ=3, only req2 valid after grant to 2 -> rr_ptr wraps to 0, req2
//    still granted next.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Purpose: requester-side and transmitter-side handshake bundle for uart_tx_arbiter.
// Latency: none; this file only groups wires.
// Backpressure: carries req_ready toward the sources and out_ready from the transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic [7:0]           out_data;
    logic                 out_ready;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    // Byte sources plus transmitter, i.e. everything around the arbiter.
    modport master (
        output req_valid, req_data, req_lock, out_ready,
        input  req_ready, out_valid, out_data, grant_id, busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, req_lock, out_ready,
        output req_ready, out_valid, out_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one UART transmitter among NUM_REQ byte sources, one byte per grant.
// Latency: byte accepted in cycle t appears on out_data at t+1; at most one byte every 2 cycles.
// Backpressure: single output buffer; while it is full, every req_ready is held low until out_ready.
// Optional message locking is compiled in with `define UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] req_ready_d;

    // Arbitration search inputs and result.
    logic [NUM_REQ-1:0] cand;
    logic [IDW-1:0]     start_ptr;
    logic [IDW-1:0]     win;
    logic               found;

    logic               lock_held_q;
`ifdef UART_ARB_LOCK_EN
    logic               lock_held_d;
    logic [IDW-1:0]     owner_q, owner_d;
`else
    logic               unused_lock;
    assign lock_held_q = 1'b0;
    assign unused_lock = ^bus.req_lock;
`endif

    // While a lock is held only the owner may compete; otherwise everyone, from rr_ptr.
    always_comb begin
        cand      = bus.req_valid;
        start_ptr = rr_ptr_q;
`ifdef UART_ARB_LOCK_EN
        if (lock_held_q) begin
            cand      = '0;
            cand[owner_q] = bus.req_valid[owner_q];
            start_ptr = owner_q;
        end
`endif
    end

    // First candidate found walking start_ptr, start_ptr+1, ... modulo NUM_REQ.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, start_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            idx = sum[IDW-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next state: capture the winner's byte in IDLE, hand it off in BUSY.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        req_ready_d = '0;
`ifdef UART_ARB_LOCK_EN
        lock_held_d = lock_held_q;
        owner_d     = owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_d[win] = 1'b1;
                    out_data_d       = bus.req_data[{win, 3'b000} +: 8];
                    grant_d          = win;
                    state_d          = BUSY;
`ifdef UART_ARB_LOCK_EN
                    lock_held_d      = bus.req_lock[win];
                    owner_d          = win;
`endif
                end
            end
            BUSY: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    // A held lock pins the pointer; releasing resumes after the owner.
                    if (!lock_held_q) begin
                        rr_ptr_d = (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + IDW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output buffer registers; reset discards any buffered byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef UART_ARB_LOCK_EN
    // Lock ownership registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_held_q <= 1'b0;
            owner_q     <= '0;
        end else begin
            lock_held_q <= lock_held_d;
            owner_q     <= owner_d;
        end
    end
`endif

    assign bus.req_ready = req_ready_d;
    assign bus.out_valid = (state_q == BUSY);
    assign bus.out_data  = out_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q == BUSY) | lock_held_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: randomized and directed check of uart_tx_arbiter against a transaction-level model.
// Latency: model holds one buffered byte; a grant shows on the outputs one cycle after acceptance.
// Backpressure: out_ready is randomized; the model blocks new grants while its buffer is full.
module tb_uart_tx_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: one buffered byte with its source, round-robin pointer, optional lock.
    bit         m_full;
    logic [7:0] m_byte;
    int         m_id;
    int         m_ptr;
    bit         m_lock;
    int         m_owner;
    logic [7:0] log_q[$];
    logic [N-1:0] acc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        if (m_lock) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_in(input logic [N-1:0] v, input logic [8*N-1:0] d,
                          input logic [N-1:0] l, input logic ordy);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_lock  = l;
        bus.out_ready = ordy;
    endtask

    // Compare DUT against the model for the current cycle, then advance the model over the edge.
    task automatic cycle();
        int w;
        logic [N-1:0] exp_rdy;
        #1;
        exp_rdy = '0;
        w = -1;
        if (!m_full) begin
            w = pick(bus.req_valid);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        check("out_valid", bus.out_valid, m_full);
        if (m_full) begin
            check("out_data", bus.out_data, m_byte);
            check("grant_id", bus.grant_id, m_id);
        end
        check("req_ready", bus.req_ready, exp_rdy);
        check("busy", bus.busy, m_full | m_lock);
        acc = exp_rdy;
        if (m_full) begin
            if (bus.out_ready) begin
                log_q.push_back(m_byte);
                m_full = 1'b0;
                if (!m_lock) m_ptr = (m_id + 1) % N;
            end
        end else if (w >= 0) begin
            m_full = 1'b1;
            m_byte = bus.req_data[8*w +: 8];
            m_id   = w;
`ifdef UART_ARB_LOCK_EN
            m_lock  = bus.req_lock[w];
            m_owner = w;
`endif
        end
        @(negedge clk);
    endtask

    // Asynchronous reset applied at a negedge; outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        m_full = 1'b0; m_byte = '0; m_id = 0; m_ptr = 0; m_lock = 1'b0; m_owner = 0;
        log_q.delete();
    endtask

    initial begin
        logic [7:0] d0, d1;
        int a, b;
        logic [7:0] exp3 [6];
        logic [7:0] exp5 [4];
        exp3 = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
`ifdef UART_ARB_LOCK_EN
        exp5 = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
`else
        exp5 = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
`endif
        set_in('0, '0, '0, 1'b0);
        @(negedge clk);
        do_reset();

        // Reset mid-BUSY after the pointer has moved past requester 0.
        set_in(3'b001, 24'h000001, '0, 1'b1); cycle();
        set_in(3'b010, 24'h000200, '0, 1'b1); cycle();
        set_in(3'b010, 24'h000200, '0, 1'b0); cycle();
        check("t1_grant_before_rst", bus.grant_id, 1);
        set_in('0, '0, '0, 1'b0);
        do_reset();
        set_in(3'b011, 24'h000201, '0, 1'b1);
        #1 check("t1_rr_ptr_reset", bus.req_ready, 3'b001);
        cycle();

        // Single byte latency.
        do_reset();
        set_in(3'b001, 24'h000041, '0, 1'b1);
        #1 check("t2_ready", bus.req_ready, 3'b001);
        cycle();
        set_in('0, '0, '0, 1'b1);
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_out_data", bus.out_data, 8'h41);
        check("t2_grant", bus.grant_id, 0);
        cycle();
        check("t2_idle", bus.out_valid, 0);
        check("t2_log", (log_q.size() == 1) ? log_q[0] : 8'hxx, 8'h41);

        // Two sources alternate.
        do_reset();
        d0 = 8'h10; d1 = 8'h20;
        for (int i = 0; i < 40 && log_q.size() < 6; i++) begin
            set_in(3'b011, {8'h00, d1, d0}, '0, 1'b1);
            cycle();
            if (acc[0]) d0++;
            if (acc[1]) d1++;
        end
        check("t3_count", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) check("t3_order", log_q[i], exp3[i]);

        // Long backpressure holds the buffer.
        do_reset();
        set_in(3'b001, 24'h000055, '0, 1'b0); cycle();
        set_in(3'b011, 24'h006655, '0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            #1;
            check("t4_hold_data", bus.out_data, 8'h55);
            check("t4_hold_ready", bus.req_ready, 3'b000);
            cycle();
        end
        set_in('0, '0, '0, 1'b1); cycle();
        check("t4_released", bus.out_valid, 0);
        check("t4_log", (log_q.size() == 1) ? log_q[0] : 8'hxx, 8'h55);

        // Three-byte message from req0 competing with req1.
        do_reset();
        a = 0; b = 0;
        for (int i = 0; i < 60 && log_q.size() < 4; i++) begin
            set_in({1'b0, 1'b1, (a < 3)}, {8'h00, 8'(8'hB0 + b), 8'(8'hA0 + a)},
                   {2'b00, (a < 2)}, 1'b1);
            cycle();
            if (acc[0]) a++;
            if (acc[1]) b++;
        end
        check("t5_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) check("t5_order", log_q[i], exp5[i]);

        // Pointer wraps after the last requester; it is still the only one served.
        do_reset();
        set_in(3'b100, 24'hC00000, '0, 1'b1);
        #1 check("t6_ready_a", bus.req_ready, 3'b100);
        cycle();
        check("t6_grant_a", bus.grant_id, 2);
        cycle();
        #1 check("t6_ready_b", bus.req_ready, 3'b100);
        cycle();
        check("t6_grant_b", bus.grant_id, 2);
        cycle();

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                set_in('0, '0, '0, 1'b0);
                do_reset();
            end
            set_in(N'($urandom), (8*N)'({$urandom, $urandom}), N'($urandom),
                   ($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
